host_cycle_ctrl: RTL and testbench

//  Sequences every CPU access that targets the host (BBC/B+/Elk/Master) bus.

---
 rtl/host_cycle_ctrl_if.sv | 30 +++
 rtl/host_cycle_ctrl.sv | 141 ++++++++++++++
 tb/tb_host_cycle_ctrl.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/host_cycle_ctrl_if.sv
// CPU-side and host-side signals of the host bus cycle controller.
// The controller takes the slave modport; the CPU/host environment takes the master modport.
interface host_cycle_ctrl_if;
   logic [1:0] j;
   logic       host_phi;
   logic       cpu_valid;
   logic       host_access;
   logic       cpu_rnw;
   logic [7:0] cpu_data;
   logic       dec_rom_reg;
   logic       dec_shadow_reg;
   logic       dec_fe4x;
   logic       lat_en;
   logic       cpu_rdy;
   logic [3:0] rom_bank;
   logic       shadow_en;
   logic       timeout_err;

   modport master (
      output j, host_phi, cpu_valid, host_access, cpu_rnw, cpu_data,
             dec_rom_reg, dec_shadow_reg, dec_fe4x,
      input  lat_en, cpu_rdy, rom_bank, shadow_en, timeout_err
   );

   modport slave (
      input  j, host_phi, cpu_valid, host_access, cpu_rnw, cpu_data,
             dec_rom_reg, dec_shadow_reg, dec_fe4x,
      output lat_en, cpu_rdy, rom_bank, shadow_en, timeout_err
   );
endinterface

// File: rtl/host_cycle_ctrl.sv
// Aligns CPU host-bus accesses to the host phase clock, stretches 1MHz accesses,
// and snoops completed writes to the paged ROM select and shadow registers.
module host_cycle_ctrl #(
   parameter int SYNC_STAGES = 2,
   parameter int PHI_TIMEOUT = 255
) (
   input logic              i_clk,
   input logic              i_rst,
   host_cycle_ctrl_if.slave bus
);
   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_FALL,
      S_PH1,
      S_PH2,
      S_DONE
   } state_t;

   localparam logic [7:0] TCNT_LAST = 8'(PHI_TIMEOUT - 1);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_phi_d;
   state_t                 r_state;
   state_t                 w_state_nxt;
   logic                   r_stretch;
   logic                   r_extra;
   logic                   r_wr;
   logic                   r_rom;
   logic                   r_shd;
   logic                   r_abort;
   logic [7:0]             r_tcnt;
   logic                   r_lat_en;
   logic [3:0]             r_rom_bank;
   logic                   r_shadow_en;
   logic                   r_timeout_err;

   logic w_phi_s;
   logic w_fall;
   logic w_rise;
   logic w_req;
   logic w_waiting;
   logic w_abort;
   logic w_set_extra;
   logic w_commit;
   logic w_unused_data;

   assign w_phi_s       = r_sync[SYNC_STAGES-1];
   assign w_fall        = ~w_phi_s & r_phi_d;
   assign w_rise        = w_phi_s & ~r_phi_d;
   assign w_req         = bus.cpu_valid & bus.host_access;
   assign w_waiting     = (r_state == S_WAIT_FALL) || (r_state == S_PH1) || (r_state == S_PH2);
   assign w_abort       = w_waiting && (r_tcnt == TCNT_LAST);
   assign w_commit      = (r_state == S_DONE) && r_wr && !r_abort;
   assign w_unused_data = &{1'b0, bus.cpu_data[6:4]};

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sync  <= '0;
         r_phi_d <= 1'b0;
      end else begin
         r_sync  <= {r_sync[SYNC_STAGES-2:0], bus.host_phi};
         r_phi_d <= w_phi_s;
      end
   end

   always_comb begin
      // NOTE: defaults first so no path through the case leaves a signal unassigned (no latches).
      w_state_nxt = r_state;
      w_set_extra = 1'b0;
      case (r_state)
         S_IDLE:      if (w_req)  w_state_nxt = S_WAIT_FALL;
         S_WAIT_FALL: if (w_fall) w_state_nxt = S_PH1;
         S_PH1:       if (w_rise) w_state_nxt = S_PH2;
         S_PH2: begin
            if (w_fall) begin
               if (r_stretch && !r_extra) begin
                  w_state_nxt = S_PH1;
                  w_set_extra = 1'b1;
               end else begin
                  w_state_nxt = S_DONE;
               end
            end
         end
         S_DONE:      w_state_nxt = S_IDLE;
         default:     w_state_nxt = S_IDLE;
      endcase
      // A stuck host clock must never hang the CPU.
      if (w_abort) begin
         w_state_nxt = S_DONE;
         w_set_extra = 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state       <= S_IDLE;
         r_lat_en      <= 1'b0;
         r_stretch     <= 1'b0;
         r_extra       <= 1'b0;
         r_wr          <= 1'b0;
         r_rom         <= 1'b0;
         r_shd         <= 1'b0;
         r_abort       <= 1'b0;
         r_tcnt        <= '0;
         r_rom_bank    <= '0;
         r_shadow_en   <= 1'b0;
         r_timeout_err <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_lat_en <= (w_state_nxt == S_PH1) || (w_state_nxt == S_PH2);
         if ((r_state == S_IDLE) && w_req) begin
            r_stretch <= bus.dec_fe4x;
            r_wr      <= ~bus.cpu_rnw;
            r_rom     <= bus.dec_rom_reg;
            r_shd     <= bus.dec_shadow_reg;
            r_extra   <= 1'b0;
            r_abort   <= 1'b0;
            r_tcnt    <= '0;
         end else if (w_waiting) begin
            r_tcnt <= r_tcnt + 8'd1;
         end
         if (w_set_extra) r_extra <= 1'b1;
         if (w_abort) begin
            r_abort       <= 1'b1;
            r_timeout_err <= 1'b1;
         end
         // Snoop: data is still held by the stalled CPU during DONE.
         if (w_commit) begin
            if (r_rom) r_rom_bank <= bus.cpu_data[3:0];
            if (r_shd && (bus.j == 2'b01)) r_shadow_en <= bus.cpu_data[7];
            if (r_shd && (bus.j == 2'b11)) r_shadow_en <= bus.cpu_data[2];
         end
      end
   end

   assign bus.cpu_rdy     = ((r_state == S_IDLE) && !w_req) || (r_state == S_DONE);
   assign bus.lat_en      = r_lat_en;
   assign bus.rom_bank    = r_rom_bank;
   assign bus.shadow_en   = r_shadow_en;
   assign bus.timeout_err = r_timeout_err;
endmodule

// File: tb/tb_host_cycle_ctrl.sv
// Self-checking bench: an event-counting transaction model checked every cycle,
// plus directed accesses with hand-computed expectations.
module tb_host_cycle_ctrl;
   localparam int PHI_TIMEOUT = 255;

   logic clk = 1'b0;
   logic rst = 1'b1;

   host_cycle_ctrl_if bus();

   host_cycle_ctrl #(.SYNC_STAGES(2), .PHI_TIMEOUT(PHI_TIMEOUT)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Host phase clock: 16 clk period, 8 high / 8 low, or held high when stuck.
   bit phi_stuck = 1'b0;
   int pc = 0;
   initial begin
      bus.host_phi = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (phi_stuck) bus.host_phi = 1'b1;
         else begin
            pc++;
            bus.host_phi = (pc % 16) < 8;
         end
      end
   end

   // Transaction model: an accepted access waits for an ordered list of synchronised
   // phi edges (F R F, or F R F R F for 1MHz); the latch is open from the first
   // fall until the list is exhausted; the ready pulse follows one clock later.
   bit         m_valid = 1'b0;
   bit         m_busy, m_done, m_started, m_abort, m_wr, m_rom, m_shd;
   bit         m_terr, m_shadow;
   logic [3:0] m_rom_bank;
   logic [7:0] m_data;
   int         m_age;
   bit         ev_q[$];
   bit [3:1]   hh;

   always @(negedge clk) begin : model
      bit req, fall, rise, exp_lat, exp_rdy;
      req  = bus.cpu_valid & bus.host_access;
      fall = !hh[2] && hh[3];
      rise = hh[2] && !hh[3];
      if (m_valid) begin
         exp_lat = m_busy && m_started && !m_done;
         exp_rdy = m_done || (!m_busy && !req);
         check("lat_en", int'(bus.lat_en), int'(exp_lat));
         check("cpu_rdy", int'(bus.cpu_rdy), int'(exp_rdy));
         check("rom_bank", int'(bus.rom_bank), int'(m_rom_bank));
         check("shadow_en", int'(bus.shadow_en), int'(m_shadow));
         check("timeout_err", int'(bus.timeout_err), int'(m_terr));
      end
      if (rst) begin
         m_busy = 0; m_done = 0; m_started = 0; m_abort = 0;
         m_terr = 0; m_shadow = 0; m_rom_bank = '0;
         ev_q = {};
         hh = '0;
         m_valid = 1'b1;
      end else begin
         if (m_done) begin
            if (m_wr && !m_abort) begin
               if (m_rom) m_rom_bank = m_data[3:0];
               if (m_shd && bus.j == 2'b01) m_shadow = m_data[7];
               if (m_shd && bus.j == 2'b11) m_shadow = m_data[2];
            end
            m_done = 0;
            m_busy = 0;
         end else if (m_busy) begin
            if (m_age == PHI_TIMEOUT - 1) begin
               m_done = 1; m_abort = 1; m_terr = 1;
            end else if (ev_q.size() > 0 &&
                         ((ev_q[0] == 1'b0 && fall) || (ev_q[0] == 1'b1 && rise))) begin
               void'(ev_q.pop_front());
               m_started = 1;
               if (ev_q.size() == 0) m_done = 1;
            end
            m_age++;
         end else if (req) begin
            m_busy = 1; m_age = 0; m_started = 0; m_abort = 0;
            m_wr = !bus.cpu_rnw; m_rom = bus.dec_rom_reg; m_shd = bus.dec_shadow_reg;
            m_data = bus.cpu_data;
            ev_q = {1'b0, 1'b1, 1'b0};
            if (bus.dec_fe4x) begin
               ev_q.push_back(1'b1);
               ev_q.push_back(1'b0);
            end
         end
         hh = {hh[2:1], bus.host_phi};
      end
   end

   // One CPU access; holds everything stable until the ready pulse.
   task automatic access(input bit rnw, input logic [7:0] d, input bit rom, input bit shd,
                         input bit fe4x, output int lat_cnt, output int stall);
      bit ok;
      @(posedge clk);
      #1;
      bus.cpu_valid = 1'b1; bus.host_access = 1'b1; bus.cpu_rnw = rnw; bus.cpu_data = d;
      bus.dec_rom_reg = rom; bus.dec_shadow_reg = shd; bus.dec_fe4x = fe4x;
      lat_cnt = 0; stall = 0; ok = 1'b0;
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         if (bus.lat_en) lat_cnt++;
         if (bus.cpu_rdy) begin
            ok = 1'b1;
            break;
         end
         stall++;
      end
      if (!ok) check("rdy_wait_expired", 0, 1);
      @(posedge clk);
      #1;
      bus.cpu_valid = 1'b0; bus.host_access = 1'b0; bus.cpu_rnw = 1'b1;
      bus.dec_rom_reg = 1'b0; bus.dec_shadow_reg = 1'b0; bus.dec_fe4x = 1'b0;
   endtask

   initial begin
      int lat, stall;
      bit seen;
      bus.j = 2'b00; bus.cpu_valid = 1'b0; bus.host_access = 1'b0; bus.cpu_rnw = 1'b1;
      bus.cpu_data = 8'h00; bus.dec_rom_reg = 1'b0; bus.dec_shadow_reg = 1'b0;
      bus.dec_fe4x = 1'b0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      check("rst_lat_en", int'(bus.lat_en), 0);
      check("rst_cpu_rdy", int'(bus.cpu_rdy), 1);
      check("rst_rom_bank", int'(bus.rom_bank), 0);
      check("rst_timeout_err", int'(bus.timeout_err), 0);

      // Plain Beeb read: one full host cycle under the latch.
      access(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, lat, stall);
      check("t1_lat_cycles", lat, 16);
      check("t1_rom_bank", int'(bus.rom_bank), 0);

      // ROM select write, then a read of the same register must not disturb it.
      access(1'b0, 8'h0C, 1'b1, 1'b0, 1'b0, lat, stall);
      check("t2_rom_write", int'(bus.rom_bank), 12);
      access(1'b1, 8'h05, 1'b1, 1'b0, 1'b0, lat, stall);
      check("t2_rom_read", int'(bus.rom_bank), 12);

      // 1MHz region: two host cycles.
      access(1'b1, 8'h00, 1'b0, 1'b0, 1'b1, lat, stall);
      check("t3_lat_cycles", lat, 32);

      // Shadow register snooping per machine type.
      bus.j = 2'b01;
      access(1'b0, 8'h80, 1'b0, 1'b1, 1'b0, lat, stall);
      check("t4_bplus_80", int'(bus.shadow_en), 1);
      bus.j = 2'b11;
      access(1'b0, 8'h80, 1'b0, 1'b1, 1'b0, lat, stall);
      check("t4_master_80", int'(bus.shadow_en), 0);
      access(1'b0, 8'h04, 1'b0, 1'b1, 1'b0, lat, stall);
      check("t4_master_04", int'(bus.shadow_en), 1);
      bus.j = 2'b00;
      access(1'b0, 8'h00, 0, 1'b1, 1'b0, lat, stall);
      check("t4_beeb_ignored", int'(bus.shadow_en), 1);

      // Stuck host clock: one IDLE request cycle plus 255 waiting cycles, then abort.
      phi_stuck = 1'b1;
      repeat (8) @(posedge clk);
      access(1'b0, 8'h0F, 1'b1, 1'b0, 1'b0, lat, stall);
      check("t5_stall_cycles", stall, 256);
      check("t5_lat_cycles", lat, 0);
      check("t5_timeout_err", int'(bus.timeout_err), 1);
      check("t5_no_commit", int'(bus.rom_bank), 12);
      phi_stuck = 1'b0;
      repeat (20) @(posedge clk);

      // Reset in the middle of a stretched access.
      #1;
      bus.cpu_valid = 1'b1; bus.host_access = 1'b1; bus.cpu_rnw = 1'b1; bus.dec_fe4x = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (bus.lat_en) begin
            seen = 1'b1;
            break;
         end
      end
      check("t6_lat_seen", int'(seen), 1);
      repeat (12) @(negedge clk);
      check("t6_mid_lat", int'(bus.lat_en), 1);
      @(posedge clk);
      #1;
      rst = 1'b1;
      bus.cpu_valid = 1'b0; bus.host_access = 1'b0; bus.dec_fe4x = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("t6_lat_en", int'(bus.lat_en), 0);
      check("t6_cpu_rdy", int'(bus.cpu_rdy), 1);
      check("t6_rom_bank", int'(bus.rom_bank), 0);
      check("t6_timeout_err", int'(bus.timeout_err), 0);

      // Normal operation resumes after reset.
      access(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, lat, stall);
      check("t6_after_lat", lat, 16);

      repeat (4) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
